rcs_serial_sub: RTL and testbench
=================================

Name: rcs_serial_sub

Overview:
Bit-serial subtractor that computes A - B LSB-first. It processes one bit per clock through a single full-adder cell, with B inverted and carry-in seeded to 1. It sits beside the ripple-carry subtractor path as the low-area alternative: it takes operands from the upstream register stage via a start/done handshake and hands the difference, borrow and overflow flags downstream. It is the sequential consumer of the same 1-bit full-adder cell used by the ripple-carry subtractor.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).
CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE or DONE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
busy  output  1  high while bits are being processed (RUN state)
done  output  1  one-cycle pulse; results valid from this cycle on
diff  output  WIDTH  registered A - B, modulo 2^WIDTH
borrow  output  1  1 when unsigned A < B (inverse of final carry-out)
overflow  output  1  signed two's-complement overflow of A - B

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy=0, done=0, diff=0, borrow=0, overflow=0. Shift registers, carry and counter all cleared. Release is synchronous to the next clk edge.
- States: IDLE, RUN, DONE. The encoding is local; see the package below.
- IDLE: start=1 at an edge captures the operands:
  - sa <= a; sb <= ~b; carry <= 1; cnt <= 0; state -> RUN.
  - a and b are ignored after capture; upstream may change them.
- RUN (busy=1), on each edge:
  - Cell inputs: sa[0], sb[0], carry.
  - sum bit is shifted into the MSB of result shift register sr; sa and sb shift right by 1.
  - carry <= cell cout; cnt <= cnt+1.
- Final RUN edge (cnt == WIDTH-1):
  - diff <= {sum, sr[WIDTH-1:1]}.
  - borrow <= ~cout.
  - overflow <= carry_in_to_msb XOR cout.
  - state -> DONE.
- DONE: done=1 for exactly this one cycle, busy=0.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation, no dead cycle); state -> RUN.
  - Otherwise state -> IDLE.
- Latency: start accepted at edge N → done high in the cycle after edge N+WIDTH. Throughput is one result per WIDTH+1 cycles.
- Output stability: diff, borrow and overflow change only on the final RUN edge. They hold their values through DONE, IDLE and the whole next RUN until that run's final edge. diff never shows partial results.
- start while busy=1 is ignored: no queuing, no error flag, and the in-flight operation is unaffected.
- Reset mid-RUN: immediate abort to the reset values. Partial results are discarded and no done pulse is produced.
- Arithmetic: all WIDTH-bit modulo; no sign extension. borrow follows unsigned semantics; overflow follows signed semantics. Both are always produced.
- busy and done are never high together. done is never high two cycles in a row.

Decomposition:
- Shared package rcs_pkg:
  - state enum (IDLE/RUN/DONE).
  - RCS_DEFAULT_WIDTH = 8.
  - The convention "carry-in seed = 1 for subtraction".
- Sub-module rcs_bit_cell: a combinational 1-bit full adder (a, b, cin → sum, cout) built from two half-adder stages plus an OR. It is instantiated once; the B inversion stays in the parent.
- The FSM, counter and shift registers stay in rcs_serial_sub.

Test Plan:
1. WIDTH=8, a=0x25, b=0x13, start 1 cycle → done 9 cycles later (edge N+8). diff=0x12, borrow=0, overflow=0. busy high exactly 8 cycles.
2. a=0x10, b=0x20 → diff=0xF0, borrow=1, overflow=0. a=0x00, b=0x00 → diff=0x00, borrow=0, overflow=0.
3. a=0x80, b=0x01 → diff=0x7F, borrow=0, overflow=1. a=0x7F, b=0xFF → diff=0x80, borrow=1, overflow=1.
4. Start a=0x55, b=0x11. Pulse start with a=0xFF, b=0x00 at RUN cycle 3 → ignored. Result is diff=0x44; done fires once at the original time.
5. Assert start during the DONE cycle with a=0x03, b=0x05 → no IDLE gap. The next done arrives 9 cycles later with diff=0xFE, borrow=1. diff holds 0x44 until then.
6. Start a=0x9A, b=0x21, drop rst_n at RUN cycle 4 → all outputs 0 immediately and no done. After release, a new start with a=0x9A, b=0x21 → diff=0x79, borrow=0, overflow=1.

Source files
------------

// File: rtl/rcs_pkg.sv
// Shared definitions for the ripple/serial subtractor family.
// Holds the sequencer state encoding and the subtraction carry-in seed.
package rcs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rcs_state_e;

    localparam int RCS_DEFAULT_WIDTH = 8;

    // A - B is computed as A + ~B + 1, so the first cell sees carry-in = 1.
    localparam logic RCS_SUB_CIN = 1'b1;

endpackage

// File: rtl/rcs_bit_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
// Shared by the ripple-carry subtractor and the bit-serial subtractor.
module rcs_bit_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic ha1_sum;
    logic ha1_carry;
    logic ha2_carry;

    assign ha1_sum   = a_i ^ b_i;
    assign ha1_carry = a_i & b_i;
    assign sum_o     = ha1_sum ^ cin_i;
    assign ha2_carry = ha1_sum & cin_i;
    assign cout_o    = ha1_carry | ha2_carry;

endmodule

// File: rtl/rcs_serial_sub.sv
// Bit-serial A - B, LSB first, one full-adder cell per clock.
// Results (diff/borrow/overflow) update only on the last bit, never partially.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one operand bit per clock, busy=1
// DONE    | one-cycle done pulse; start here restarts with no gap
module rcs_serial_sub
    import rcs_pkg::*;
#(
    parameter  int WIDTH = RCS_DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    rcs_state_e       state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-2:0] sr_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             overflow_q;

    logic             cell_sum;
    logic             cell_cout;
    logic [WIDTH-1:0] sum_word_d;

    rcs_bit_cell u_cell (
        .a_i    (sa_q[0]),
        .b_i    (sb_q[0]),
        .cin_i  (carry_q),
        .sum_o  (cell_sum),
        .cout_o (cell_cout)
    );

    // sr_q holds the already-computed low bits; the new sum bit enters at the top.
    assign sum_word_d = {cell_sum, sr_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sa_q       <= '0;
            sb_q       <= '0;
            sr_q       <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= ~b;
                        carry_q <= RCS_SUB_CIN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    sr_q    <= sum_word_d[WIDTH-1:1];
                    carry_q <= cell_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        // carry_q is the carry into the MSB at this point.
                        diff_q     <= sum_word_d;
                        borrow_q   <= ~cell_cout;
                        overflow_q <= carry_q ^ cell_cout;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_rcs_serial_sub.sv
// Self-checking bench for rcs_serial_sub (WIDTH=8): vector table, random ops
// against an arithmetic model, and hand-written handshake/reset sequences.
module tb_rcs_serial_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;

    int total = 0;
    int bad = 0;
    logic [W-1:0] last_diff = '0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    vec_t vecs[9];

    rcs_serial_sub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input int unsigned x, input int unsigned y,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        int sx;
        int sy;
        int r;
        sx = (x >= 128) ? int'(x) - 256 : int'(x);
        sy = (y >= 128) ? int'(y) - 256 : int'(y);
        r  = sx - sy;
        d  = W'((x + 256 - y) % 256);
        bo = (x < y);
        ov = (r < -128) || (r > 127);
    endfunction

    // Call at a negedge; start is sampled at the next posedge.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        a = x;
        b = y;
    endtask

    // Returns at the negedge where done is seen. inj>0 pulses a stray start at that RUN cycle.
    task automatic wait_done(input logic [W-1:0] hold, input int inj,
                             output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
            end
            if (inj > 0 && lat == inj) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'h00;
            end
            if (inj > 0 && lat == inj + 1) start = 1'b0;
            if (busy) bcnt++;
            if (busy && done) chk("busy_done_excl", 32'(busy & done), 32'd0);
            if (!done) chk("diff_hold", 32'(diff), 32'(hold));
        end while (!done && lat < 20);
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         input string tag);
        int lat;
        int bcnt;
        @(negedge clk);
        launch(x, y);
        wait_done(last_diff, 0, lat, bcnt);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
        chk({tag, "_latency"}, 32'(lat), 32'd9);
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd8);
        last_diff = ed;
        @(negedge clk);
        chk({tag, "_done_once"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int bcnt;
        bit saw_done;
        logic [W-1:0] rx, ry, ed;
        logic eb, eo;

        vecs[0] = '{8'h25, 8'h13, 8'h12, 1'b0, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};
        vecs[8] = '{8'hFF, 8'h7F, 8'h80, 1'b0, 1'b0};

        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].ovf, "vec");

        for (int i = 0; i < 40; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            model(int'(rx), int'(ry), ed, eb, eo);
            do_op(rx, ry, ed, eb, eo, "rand");
        end

        // Stray start while busy must be ignored.
        @(negedge clk);
        launch(8'h55, 8'h11);
        wait_done(last_diff, 3, lat, bcnt);
        chk("ign_diff", 32'(diff), 32'h44);
        chk("ign_latency", 32'(lat), 32'd9);
        chk("ign_busy_cycles", 32'(bcnt), 32'd8);
        last_diff = 8'h44;

        // Back-to-back restart from the DONE cycle.
        launch(8'h03, 8'h05);
        wait_done(last_diff, 0, lat, bcnt);
        chk("b2b_diff", 32'(diff), 32'hFE);
        chk("b2b_borrow", 32'(borrow), 32'd1);
        chk("b2b_ovf", 32'(overflow), 32'd0);
        chk("b2b_latency", 32'(lat), 32'd9);
        chk("b2b_busy_cycles", 32'(bcnt), 32'd8);
        last_diff = 8'hFE;
        @(negedge clk);
        chk("b2b_done_once", 32'(done), 32'd0);

        // Reset in the middle of a run.
        @(negedge clk);
        launch(8'h9A, 8'h21);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        chk("abort_ovf", 32'(overflow), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        last_diff = '0;
        do_op(8'h9A, 8'h21, 8'h79, 1'b0, 1'b1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
